vreg_wb_sequencer: RTL

- Write-side feeder for the vector register file's single-element write port (we, reg_num, index, data_in).
- Accepts a whole vector result plus destination register and lane mask over a valid/ready handshake.
- Serialises the enabled lanes into one element write per cycle.
- Sits between the vector execute/load stage and the register file; its vector input uses the same packing as the register file's full-vector read port, so a read vector can be written back unchanged.

---
 rtl/vrf_pkg.sv | 20 ++
 rtl/lane_prio_enc.sv | 29 ++
 rtl/vreg_wb_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/vrf_pkg.sv
// Shared defaults and types for the vector register file write path.
package vrf_pkg;

  localparam int WIDTH        = 24;
  localparam int REGNUM       = 16;
  localparam int VECTOR_WIDTH = 8;

  localparam int REG_AW = $clog2(REGNUM);
  localparam int IDX_AW = $clog2(VECTOR_WIDTH);

  typedef logic [WIDTH-1:0] elem_t;
  // Element i lives in slot [VECTOR_WIDTH-1-i], so element 0 is the MSB slot.
  typedef elem_t [VECTOR_WIDTH-1:0] vec_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wb_state_t;

endpackage

// File: rtl/lane_prio_enc.sv
// Lowest-set-bit encoder over the remaining lane mask, plus a flag that
// says the mask holds exactly one lane (the write in progress is the last).
module lane_prio_enc
  import vrf_pkg::*;
#(
  parameter int VECTOR_WIDTH = vrf_pkg::VECTOR_WIDTH
) (
  input  logic [VECTOR_WIDTH-1:0]         mask,
  output logic [$clog2(VECTOR_WIDTH)-1:0] idx,
  output logic                            one_left
);

  localparam int IAW = $clog2(VECTOR_WIDTH);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx = '0;
    for (int i = VECTOR_WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) idx = IAW'(i);
    end
  end

  // A nonzero mask with no second bit set: clearing the lowest bit leaves zero.
  always_comb begin
    one_left = (mask != '0) &&
               ((mask & (mask - VECTOR_WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/vreg_wb_sequencer.sv
// Vector write-back sequencer: accepts a whole vector with a lane mask and
// issues one element write per cycle to the register file, lowest lane first.
module vreg_wb_sequencer
  import vrf_pkg::*;
#(
  parameter int WIDTH        = vrf_pkg::WIDTH,
  parameter int REGNUM       = vrf_pkg::REGNUM,
  parameter int VECTOR_WIDTH = vrf_pkg::VECTOR_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [$clog2(REGNUM)-1:0]            in_reg,
  input  logic [VECTOR_WIDTH-1:0]              in_mask,
  input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   in_vec,
  output logic                                 wr_en,
  output logic [$clog2(REGNUM)-1:0]            wr_reg,
  output logic [$clog2(VECTOR_WIDTH)-1:0]      wr_index,
  output logic [WIDTH-1:0]                     wr_data,
  output logic                                 busy,
  output logic                                 done
);

  localparam int RAW = $clog2(REGNUM);
  localparam int IAW = $clog2(VECTOR_WIDTH);

  wb_state_t                            state_q, state_d;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   hold_vec_q, hold_vec_d;
  logic [RAW-1:0]                       hold_reg_q, hold_reg_d;
  logic [VECTOR_WIDTH-1:0]              rem_mask_q, rem_mask_d;
  logic                                 done_q, done_d;
  // Last values presented to the regfile, held while not writing.
  logic [RAW-1:0]                       last_reg_q, last_reg_d;
  logic [IAW-1:0]                       last_idx_q, last_idx_d;
  logic [WIDTH-1:0]                     last_data_q, last_data_d;

  logic [IAW-1:0]                       cur_idx;
  logic [IAW-1:0]                       cur_slot;
  logic                                 one_left;
  logic                                 writing;
  logic                                 accept;
  logic [WIDTH-1:0]                     cur_data;

  lane_prio_enc #(
    .VECTOR_WIDTH(VECTOR_WIDTH)
  ) u_lane_prio_enc (
    .mask    (rem_mask_q),
    .idx     (cur_idx),
    .one_left(one_left)
  );

  assign writing  = (state_q == WRITE);
  assign cur_slot = IAW'(VECTOR_WIDTH - 1) - cur_idx;
  assign cur_data = hold_vec_q[cur_slot];
  // Ready in IDLE, or on the last lane so a follow-on vector streams with no bubble.
  assign in_ready = rst_n && (!writing || one_left);
  assign accept   = in_valid && in_ready;

  assign wr_en    = writing;
  assign wr_reg   = writing ? hold_reg_q : last_reg_q;
  assign wr_index = writing ? cur_idx    : last_idx_q;
  assign wr_data  = writing ? cur_data   : last_data_q;
  assign busy     = writing;
  assign done     = done_q;

  // Next-state: retire the current lane, then let an accepted vector overwrite the holding registers.
  always_comb begin
    state_d     = state_q;
    hold_vec_d  = hold_vec_q;
    hold_reg_d  = hold_reg_q;
    rem_mask_d  = rem_mask_q;
    done_d      = 1'b0;
    last_reg_d  = last_reg_q;
    last_idx_d  = last_idx_q;
    last_data_d = last_data_q;

    if (writing) begin
      rem_mask_d  = rem_mask_q & ~(VECTOR_WIDTH'(1) << cur_idx);
      last_reg_d  = hold_reg_q;
      last_idx_d  = cur_idx;
      last_data_d = cur_data;
      if (one_left) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end

    if (accept) begin
      hold_vec_d = in_vec;
      hold_reg_d = in_reg;
      rem_mask_d = in_mask;
      if (in_mask == '0) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        state_d = WRITE;
      end
    end
  end

  // State and holding registers; reset discards any pending vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_vec_q  <= '0;
      hold_reg_q  <= '0;
      rem_mask_q  <= '0;
      done_q      <= 1'b0;
      last_reg_q  <= '0;
      last_idx_q  <= '0;
      last_data_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_vec_q  <= hold_vec_d;
      hold_reg_q  <= hold_reg_d;
      rem_mask_q  <= rem_mask_d;
      done_q      <= done_d;
      last_reg_q  <= last_reg_d;
      last_idx_q  <= last_idx_d;
      last_data_q <= last_data_d;
    end
  end

endmodule
